conv_window_gen: RTL and testbench

//  Downstream of the conv FIFO/line-buffer controller: consumes its raster pixel stream
//  and produces 3x3 convolution windows, decimated by stride (1 or 2), to the MAC array.

---
 rtl/conv_window_gen.sv | 146 ++++++++++++++
 tb/tb_conv_window_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// 3x3 convolution window generator: two line buffers plus a window register, stride 1/2 decimation.
// Optional protocol checker (sticky err output) enabled by defining CONV_WIN_PROTO_CHK_EN.
module conv_window_gen #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_ROW = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        cfg_row_len,
  input  logic [4:0]        cfg_col_len,
  input  logic [2:0]        cfg_stride,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [9*DATA_W-1:0] win_data,
  output logic [4:0]        win_row,
  output logic [4:0]        win_col,
  output logic              busy,
  output logic              frame_done
`ifdef CONV_WIN_PROTO_CHK_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t             state, state_nxt;
  logic [4:0]         row_len, col_len, row, col;
  logic               s2;
  logic [DATA_W-1:0]  lb0 [MAX_ROW];
  logic [DATA_W-1:0]  lb1 [MAX_ROW];
  logic [DATA_W-1:0]  hist [6];
  logic [DATA_W-1:0]  win_nxt [9];
  logic [9*DATA_W-1:0] win_flat;
  logic               accept, last_px, emit, start_ok;
  logic [4:0]         row_m2, col_m2;

  assign in_ready   = (state == RUN) && (!win_valid || win_ready);
  assign accept     = in_valid && in_ready;
  assign busy       = (state == RUN) || (state == FLUSH);
  assign frame_done = (state == DONE);
  assign row_m2     = row - 5'd2;
  assign col_m2     = col - 5'd2;
  assign last_px    = (row == col_len - 5'd1) && (col == row_len - 5'd1);
  assign start_ok   = start && (cfg_row_len >= 5'd3) && (cfg_col_len >= 5'd3);
  assign emit       = accept && (row >= 5'd2) && (col >= 5'd2) &&
                      (!s2 || (!row_m2[0] && !col_m2[0]));

  // hist keeps only the two newest columns; the oldest column of the next window is hist col 0
  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      win_nxt[3*r]   = hist[2*r];
      win_nxt[3*r+1] = hist[2*r+1];
      win_nxt[3*r+2] = '0;
    end
    win_nxt[2] = lb1[col];
    win_nxt[5] = lb0[col];
    win_nxt[8] = in_data;
    win_flat   = '0;
    for (int unsigned i = 0; i < 9; i++)
      win_flat[i*DATA_W +: DATA_W] = win_nxt[i];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (accept && last_px) state_nxt = FLUSH;
      FLUSH:   if (!win_valid || win_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row_len   <= '0;
      col_len   <= '0;
      s2        <= 1'b0;
      row       <= '0;
      col       <= '0;
      win_valid <= 1'b0;
      win_data  <= '0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_ok) begin
        row_len <= cfg_row_len;
        col_len <= cfg_col_len;
        s2      <= (cfg_stride == 3'd2);
        row     <= '0;
        col     <= '0;
      end
      if (accept) begin
        if (col == row_len - 5'd1) begin
          col <= '0;
          row <= row + 5'd1;
        end else begin
          col <= col + 5'd1;
        end
      end
      if (emit) begin
        win_valid <= 1'b1;
        win_data  <= win_flat;
        win_row   <= s2 ? {1'b0, row_m2[4:1]} : row_m2;
        win_col   <= s2 ? {1'b0, col_m2[4:1]} : col_m2;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

  // Line buffers and window history are data-only and deliberately not reset
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= in_data;
      for (int unsigned r = 0; r < 3; r++) begin
        hist[2*r]   <= win_nxt[3*r+1];
        hist[2*r+1] <= win_nxt[3*r+2];
      end
    end
  end

`ifdef CONV_WIN_PROTO_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      if (in_valid && (state != RUN))
        err <= 1'b1;
      if (state == IDLE && start &&
          ((cfg_row_len < 5'd3) || (cfg_col_len < 5'd3) ||
           ((cfg_stride != 3'd1) && (cfg_stride != 3'd2))))
        err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: reference window list built from frame geometry,
// compared on every window handshake, plus literal checks of first/last windows and counts.
module tb_conv_window_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  cfg_row_len = '0;
  logic [4:0]  cfg_col_len = '0;
  logic [2:0]  cfg_stride = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        win_valid;
  logic        win_ready = 1'b1;
  logic [71:0] win_data;
  logic [4:0]  win_row, win_col;
  logic        busy, frame_done;
`ifdef CONV_WIN_PROTO_CHK_EN
  logic        err;
`endif

  conv_window_gen #(.DATA_W(8), .MAX_ROW(31)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_row_len(cfg_row_len), .cfg_col_len(cfg_col_len), .cfg_stride(cfg_stride),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .busy(busy), .frame_done(frame_done)
`ifdef CONV_WIN_PROTO_CHK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] data;
    logic [4:0]  row;
    logic [4:0]  col;
  } win_t;

  win_t        exp_q[$];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  bit          lat_en = 0;
  bit          rnd_ready = 0;
  int          stall_req = 0;
  bit          stall_active = 0;
  bit          held_v = 0;
  logic [71:0] held;
  int          obs_cnt = 0;
  int          fd_cnt = 0;
  logic [71:0] obs_data [64];
  logic [4:0]  last_row, last_col;
  int          acc12 = -1;
  int          wv_cyc = -1;
  bit          seen_wv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: every window is a 3x3 patch of the frame at stride-aligned origins, raster order
  task automatic build_model(input int rl, input int cl, input int st);
    int s;
    win_t e;
    s = (st == 2) ? 2 : 1;
    exp_q.delete();
    for (int r0 = 0; r0 + 2 < cl; r0 += s)
      for (int c0 = 0; c0 + 2 < rl; c0 += s) begin
        e.row = 5'(r0 / s);
        e.col = 5'(c0 / s);
        e.data = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e.data[(3*r+c)*8 +: 8] = 8'((r0 + r) * rl + c0 + c);
        exp_q.push_back(e);
      end
  endtask

  // Compare process: samples on the negative edge, away from the active edge
  always @(negedge clk) begin
    win_t e;
    if (mon_en) begin
      if (lat_en && in_valid && in_ready && in_data == 8'd12) acc12 = cyc + 1;
      if (lat_en && win_valid && !seen_wv) begin
        seen_wv = 1;
        wv_cyc = cyc;
      end
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_window", {win_row, win_col, win_data[69:0]}, '0);
        end else begin
          e = exp_q.pop_front();
          chk("win_data", {8'd0, win_data}, {8'd0, e.data});
          chk("win_pos", {win_row, win_col}, {e.row, e.col});
        end
        if (obs_cnt < 64) obs_data[obs_cnt] = win_data;
        obs_cnt++;
        last_row = win_row;
        last_col = win_col;
      end
      if (frame_done) fd_cnt++;
      if (stall_active) begin
        if (!held_v) begin
          held = win_data;
          held_v = 1;
        end else begin
          chk("stall_data", {8'd0, win_data}, {8'd0, held});
        end
        chk("stall_in_ready", {79'd0, in_ready}, 80'd0);
        chk("stall_valid", {79'd0, win_valid}, 80'd1);
      end else begin
        held_v = 0;
      end
    end
  end

  // Consumer: ready always, random, or stalled for stall_req cycles on the first pending window
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_req > 0 && win_valid) begin
        win_ready = 1'b0;
        stall_req--;
        stall_active = 1;
      end else begin
        stall_active = 0;
        win_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  task automatic do_start(input int rl, input int cl, input int st);
    @(posedge clk); #1;
    cfg_row_len = 5'(rl);
    cfg_col_len = 5'(cl);
    cfg_stride  = 3'(st);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input bit rnd, input int n);
    int p = 0;
    int budget = 0;
    while (p < n && budget < 4000) begin
      @(posedge clk); #1;
      in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = 8'(p);
      @(negedge clk);
      if (in_valid && in_ready) p++;
      budget++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pixels_accepted", 80'(p), 80'(n));
  endtask

  task automatic run_frame(input int rl, input int cl, input int st, input bit rnd, input int limit);
    int n;
    int budget = 0;
    build_model(rl, cl, st);
    obs_cnt = 0;
    fd_cnt = 0;
    mon_en = 1;
    do_start(rl, cl, st);
    n = (limit < rl * cl) ? limit : rl * cl;
    send(rnd, n);
    if (n == rl * cl) begin
      while (!(fd_cnt > 0 && !busy) && budget < 300) begin
        @(posedge clk); #2;
        budget++;
      end
      chk("frame_done_pulses", 80'(fd_cnt), 80'd1);
      chk("windows_left", 80'(exp_q.size()), 80'd0);
      chk("busy_after_frame", {79'd0, busy}, 80'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {79'd0, in_ready}, 80'd0);
    chk("rst_win_valid", {79'd0, win_valid}, 80'd0);
    chk("rst_busy", {79'd0, busy}, 80'd0);
    chk("rst_frame_done", {79'd0, frame_done}, 80'd0);
    chk("rst_win_pos", {win_row, win_col}, 80'd0);
    chk("rst_win_data", {8'd0, win_data}, 80'd0);
    rst = 1'b0;

    // T1: 5x5, stride 1
    lat_en = 1;
    run_frame(5, 5, 1, 0, 1000);
    lat_en = 0;
    chk("t1_count", 80'(obs_cnt), 80'd9);
    chk("t1_first_window", {8'd0, obs_data[0]}, {8'd0, 72'h0c_0b_0a_07_06_05_02_01_00});
    chk("t1_latency", 80'(wv_cyc), 80'(acc12));
    chk("t1_last_pos", {last_row, last_col}, {5'd2, 5'd2});

    // T2: 5x5, stride 2
    run_frame(5, 5, 2, 0, 1000);
    chk("t2_count", 80'(obs_cnt), 80'd4);
    chk("t2_win01_w00", 80'(obs_data[1][7:0]), 80'd2);
    chk("t2_win11_w22", 80'(obs_data[3][71:64]), 80'd24);
    chk("t2_last_pos", {last_row, last_col}, {5'd1, 5'd1});

    // T3: consumer stalls 10 cycles on the first window
    stall_req = 10;
    run_frame(5, 5, 1, 0, 1000);
    chk("t3_count", 80'(obs_cnt), 80'd9);
    chk("t3_first_window", {8'd0, obs_data[0]}, {8'd0, 72'h0c_0b_0a_07_06_05_02_01_00});

    // T4: reset after pixel 13, then a clean rerun of T1
    run_frame(5, 5, 1, 0, 14);
    mon_en = 0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_in_ready", {79'd0, in_ready}, 80'd0);
    chk("t4_win_valid", {79'd0, win_valid}, 80'd0);
    chk("t4_busy", {79'd0, busy}, 80'd0);
    rst = 1'b0;
    run_frame(5, 5, 1, 0, 1000);
    chk("t4_count", 80'(obs_cnt), 80'd9);
    chk("t4_first_window", {8'd0, obs_data[0]}, {8'd0, 72'h0c_0b_0a_07_06_05_02_01_00});
    chk("t4_last_pos", {last_row, last_col}, {5'd2, 5'd2});
`ifdef CONV_WIN_PROTO_CHK_EN
    chk("err_clean", {79'd0, err}, 80'd0);
`endif

    // T6: 31x4, illegal stride 3 behaves as stride 1, random valid/ready
    rnd_ready = 1;
    run_frame(31, 4, 3, 1, 1000);
    rnd_ready = 0;
    chk("t6_count", 80'(obs_cnt), 80'd58);
    chk("t6_last_pos", {last_row, last_col}, {5'd1, 5'd28});
`ifdef CONV_WIN_PROTO_CHK_EN
    chk("t6_err", {79'd0, err}, 80'd1);
`endif

    // T5: too-narrow frame is rejected
    mon_en = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef CONV_WIN_PROTO_CHK_EN
    @(negedge clk);
    chk("t5_err_cleared", {79'd0, err}, 80'd0);
`endif
    do_start(2, 5, 1);
    @(negedge clk);
    chk("t5_busy", {79'd0, busy}, 80'd0);
    chk("t5_in_ready", {79'd0, in_ready}, 80'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_busy_later", {79'd0, busy}, 80'd0);
`ifdef CONV_WIN_PROTO_CHK_EN
    chk("t5_err", {79'd0, err}, 80'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
